// File: rtl/mips_prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and word width.
package mips_prog_loader_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

  // States in which the loader listens to the byte stream and the inter-byte timer runs
  function automatic logic is_rx_state(loader_state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/mips_prog_loader_byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words; word_done pulses in the
// cycle the 4th byte is accepted, with the complete word on 'word'.
module mips_prog_loader_byte_assembler
  import mips_prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {byte_in, shift_q[WORD_W-1:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Newest byte lands in the top lane, so after four shifts the first byte sits in [7:0]
  assign word      = {byte_in, shift_q[WORD_W-1:8]};
  assign word_done = byte_valid && !clear && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader for the multicycle CPU memory; holds the CPU in reset while loading.
// Optional trailing XOR checksum word enabled by defining LOADER_CHKSUM_EN.
module mips_prog_loader
  import mips_prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 50000
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              LoadReq,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWD,
  output logic              CPU_CLR,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

`ifdef LOADER_CHKSUM_EN
  localparam loader_state_e ST_AFTER_LAST = ST_CHK;
`else
  localparam loader_state_e ST_AFTER_LAST = ST_DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  idx_next;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              cpu_clr_q, cpu_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHKSUM_EN
  logic [31:0]       chk_q, chk_d;
`endif

  logic              accept;
  logic              start;
  logic [31:0]       asm_word;
  logic              asm_done;

  assign accept   = RxValid && rx_ready_q;
  assign start    = LoadReq && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign idx_next = idx_q + IDX_W'(1);

  mips_prog_loader_byte_assembler u_asm (
    .clk        (CLK),
    .rst        (CLR),
    .clear      (start),
    .byte_valid (accept),
    .byte_in    (RxData),
    .word       (asm_word),
    .word_done  (asm_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    tmo_d      = tmo_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
`ifdef LOADER_CHKSUM_EN
    chk_d      = chk_q;
`endif

    if (is_rx_state(state_q)) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_ERR;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (LoadReq) begin
          state_d = ST_HDR;
          idx_d   = '0;
          n_d     = '0;
          tmo_d   = '0;
`ifdef LOADER_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_HDR: begin
        if (asm_done) begin
          if (asm_word == 32'd0) begin
            state_d = ST_AFTER_LAST;
          end else if (asm_word > 32'(MAX_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            n_d     = asm_word[IDX_W-1:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_done) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          mem_wd_d   = asm_word;
`ifdef LOADER_CHKSUM_EN
          chk_d      = chk_q ^ asm_word;
`endif
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_next;
        state_d = (idx_next == n_q) ? ST_AFTER_LAST : ST_DATA;
      end
`ifdef LOADER_CHKSUM_EN
      ST_CHK: begin
        if (asm_done) state_d = (asm_word == chk_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered versions of what the next state implies
    rx_ready_d = is_rx_state(state_d);
    busy_d     = (state_d == ST_HDR) || (state_d == ST_DATA) ||
                 (state_d == ST_WRITE) || (state_d == ST_CHK);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_clr_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= ADDR_W'(BASE_ADDR);
      mem_wd_q   <= '0;
      cpu_clr_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      cpu_clr_q  <= cpu_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign RxReady = rx_ready_q;
  assign MemWE   = mem_we_q;
  assign MemAddr = mem_addr_q;
  assign MemWD   = mem_wd_q;
  assign CPU_CLR = cpu_clr_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized self-checking bench for mips_prog_loader; honours LOADER_CHKSUM_EN when defined.
module tb_mips_prog_loader;

  localparam int ADDR_W = 8;
  localparam int BASE   = 0;
  localparam int MAXW   = 16;
  localparam int TMO    = 40;

  logic              CLK = 1'b0;
  logic              CLR, LoadReq, RxValid;
  logic [7:0]        RxData;
  logic              RxReady, MemWE, CPU_CLR, Busy, Done, Err;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWD;

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] wr_q[$];
  logic [31:0] words[$];

  mips_prog_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .CLR(CLR), .LoadReq(LoadReq), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
    .CPU_CLR(CPU_CLR), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory-side observer: every write strobe is logged, and the stream must be stalled meanwhile
  always @(negedge CLK) begin
    if (MemWE === 1'b1) begin
      wr_q.push_back({MemAddr, MemWD});
      check_val("rdy_low_in_write", {31'd0, RxReady}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    RxData  = b;
    RxValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      ok = RxReady;
      @(posedge CLK);
      @(negedge CLK);
      if (ok === 1'b1) return;
    end
    check_val("byte_accept_timeout", 32'd0, 32'd1);
    RxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 0; b < 4; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        RxValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic pulse_load();
    LoadReq = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    LoadReq = 1'b0;
  endtask

  task automatic apply_clr();
    RxValid = 1'b0;
    CLR = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_values();
    check_val("rst_rxready", {31'd0, RxReady}, 32'd0);
    check_val("rst_memwe",   {31'd0, MemWE},   32'd0);
    check_val("rst_memaddr", {24'd0, MemAddr}, BASE);
    check_val("rst_memwd",   MemWD,            32'd0);
    check_val("rst_cpu_clr", {31'd0, CPU_CLR}, 32'd1);
    check_val("rst_busy",    {31'd0, Busy},    32'd0);
    check_val("rst_done",    {31'd0, Done},    32'd0);
    check_val("rst_err",     {31'd0, Err},     32'd0);
  endtask

  // Whole frame: header n, payload from 'words', optional checksum (xor ^ chk_flip)
  task automatic run_frame(input int unsigned n, input bit gaps, input logic [31:0] chk_flip,
                           input bit inject_load);
    logic [31:0] x;
    logic [39:0] e;
    bit          exp_ok;
    int          exp_wr;
    wr_q.delete();
    pulse_load();
    check_val("load_cpu_held", {31'd0, CPU_CLR}, 32'd0);
    check_val("load_busy",     {31'd0, Busy},    32'd1);
    check_val("load_flags",    {30'd0, Done, Err}, 32'd0);
    send_word(n, gaps);
    if (inject_load && n != 0 && n <= MAXW) begin
      RxValid = 1'b0;
      pulse_load();
      check_val("busy_ignores_load", {31'd0, Busy}, 32'd1);
    end
    x = 32'd0;
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        send_word(words[i], gaps);
        x = x ^ words[i];
      end
`ifdef LOADER_CHKSUM_EN
      send_word(x ^ chk_flip, gaps);
`endif
    end
    RxValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done === 1'b1 || Err === 1'b1) break;
      @(negedge CLK);
    end
    exp_wr = (n <= MAXW) ? int'(n) : 0;
    exp_ok = (n <= MAXW);
`ifdef LOADER_CHKSUM_EN
    if (chk_flip != 32'd0) exp_ok = 1'b0;
`endif
    check_val("wr_count", wr_q.size(), exp_wr);
    for (int i = 0; i < exp_wr && i < wr_q.size(); i++) begin
      e = wr_q[i];
      check_val("wr_addr", {24'd0, e[39:32]}, (BASE + i) % 256);
      check_val("wr_data", e[31:0], words[i]);
    end
    check_val("end_done",    {31'd0, Done},    {31'd0, exp_ok});
    check_val("end_err",     {31'd0, Err},     {31'd0, !exp_ok});
    check_val("end_cpu_clr", {31'd0, CPU_CLR}, {31'd0, exp_ok});
    check_val("end_busy",    {31'd0, Busy},    32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    CLR = 1'b1; LoadReq = 1'b0; RxValid = 1'b0; RxData = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset_values();
    CLR = 1'b0;
    @(negedge CLK);

    // Basic two-word image, back-to-back bytes
    words = '{32'h20080005, 32'h01095020};
    run_frame(2, 1'b0, 32'd0, 1'b0);

    // Empty image
    words.delete();
    run_frame(0, 1'b0, 32'd0, 1'b0);

    // Oversized header, then rearm clears Err
    run_frame(MAXW + 1, 1'b0, 32'd0, 1'b0);
    pulse_load();
    check_val("rearm_err_clear", {31'd0, Err},  32'd0);
    check_val("rearm_busy",      {31'd0, Busy}, 32'd1);
    apply_clr();
    CLR = 1'b0;
    @(negedge CLK);

    // Largest accepted image
    words.delete();
    for (int i = 0; i < MAXW; i++) words.push_back($urandom);
    run_frame(MAXW, 1'b0, 32'd0, 1'b0);

    // Inter-byte timeout after 2 bytes of word 1
    words = '{$urandom, $urandom, $urandom};
    wr_q.delete();
    pulse_load();
    send_word(32'd3, 1'b0);
    send_word(words[0], 1'b0);
    send_byte(words[1][7:0]);
    send_byte(words[1][15:8]);
    RxValid = 1'b0;
    repeat (TMO - 1) @(negedge CLK);
    check_val("tmo_not_yet", {31'd0, Err}, 32'd0);
    @(negedge CLK);
    check_val("tmo_err", {31'd0, Err}, 32'd1);
    check_val("tmo_cpu_held", {31'd0, CPU_CLR}, 32'd0);
    check_val("tmo_wr_count", wr_q.size(), 32'd1);

    // Random frames with gaps and ignored mid-frame LoadReq
    for (int f = 0; f < 6; f++) begin
      int unsigned n;
      n = $urandom_range(1, MAXW);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_frame(n, 1'b1, 32'd0, f[0]);
    end

`ifdef LOADER_CHKSUM_EN
    words = '{32'hDEADBEEF};
    run_frame(1, 1'b0, 32'd0, 1'b0);
    run_frame(1, 1'b0, 32'h00000001, 1'b0);
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    run_frame(5, 1'b1, 32'h80000000, 1'b0);
`endif

    // Reset in the middle of a frame
    words = '{$urandom, $urandom, $urandom, $urandom};
    wr_q.delete();
    pulse_load();
    send_word(32'd4, 1'b0);
    send_word(words[0], 1'b0);
    send_byte(words[1][7:0]);
    send_byte(words[1][15:8]);
    apply_clr();
    check_reset_values();
    check_val("clr_partial_wr", wr_q.size(), 32'd1);
    CLR = 1'b0;
    @(negedge CLK);
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    run_frame(3, 1'b1, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
